// File: rtl/breath_pwm_multi_pkg.sv
// Shared definitions for the multi-channel breathing LED driver.
// Mode encodings and the counter width helper.
package breath_pwm_multi_pkg;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_ON     = 2'b01;
  localparam logic [1:0] MODE_BREATH = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  function automatic int clog2w(input int n);
    int w;
    w = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) w = k + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/breath_pwm_multi_ramp.sv
// One channel's brightness ramp: duty, direction and peak pulse.
// Sweeps 0..MAX and back, one step per PWM period, with clamping.
module breath_ramp
  import breath_pwm_multi_pkg::*;
#(
  parameter int CNT_W  = 13,
  parameter int STEP_W = 8,
  parameter int MAX    = 4799
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_restart,
  input  logic              i_tick,
  input  logic [1:0]        i_mode,
  input  logic [STEP_W-1:0] i_step,
  input  logic [CNT_W-1:0]  i_init,
  output logic [CNT_W-1:0]  o_duty,
  output logic              o_dir,
  output logic              o_peak
);

  localparam int SUM_W =
    ((CNT_W > STEP_W) ? CNT_W : STEP_W) + 1;
  localparam logic [SUM_W-1:0] MAX_W = SUM_W'(MAX);
  localparam logic [CNT_W-1:0] MAX_D = CNT_W'(MAX);

  logic [CNT_W-1:0] r_duty;
  logic             r_dir;
  logic             r_peak;

  logic [SUM_W-1:0] w_duty;
  logic [SUM_W-1:0] w_step;
  logic [SUM_W-1:0] w_sum;
  logic             w_run;
  logic             w_top;
  logic             w_bot;
  logic [CNT_W-1:0] w_duty_nx;
  logic             w_dir_nx;
  logic             w_peak_nx;

  assign w_duty = SUM_W'(r_duty);
  assign w_step = SUM_W'(i_step);
  assign w_sum  = w_duty + w_step;
  assign w_top  = (w_sum >= MAX_W);
  assign w_bot  = (w_duty <= w_step);
  assign w_run  = i_tick && (i_step != '0) &&
                  ((i_mode == MODE_BREATH) ||
                   (i_mode == MODE_BLINK));

  // Next ramp state: clamp at both ends, flip direction there.
  always_comb begin
    w_duty_nx = r_duty;
    w_dir_nx  = r_dir;
    w_peak_nx = 1'b0;
    if (w_run) begin
      if (!r_dir) begin
        if (w_top) begin
          w_duty_nx = MAX_D;
          w_dir_nx  = 1'b1;
          w_peak_nx = 1'b1;
        end else begin
          w_duty_nx = r_duty + w_step[CNT_W-1:0];
        end
      end else begin
        if (w_bot) begin
          w_duty_nx = '0;
          w_dir_nx  = 1'b0;
        end else begin
          w_duty_nx = r_duty - w_step[CNT_W-1:0];
        end
      end
    end
  end

  // Ramp registers; reset and restart reload the start point.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      r_duty <= i_init;
      r_dir  <= 1'b0;
      r_peak <= 1'b0;
    end else begin
      r_duty <= w_duty_nx;
      r_dir  <= w_dir_nx;
      r_peak <= w_peak_nx;
    end
  end

  assign o_duty = r_duty;
  assign o_dir  = r_dir;
  assign o_peak = r_peak;

endmodule

// File: rtl/breath_pwm_multi.sv
// Multi-channel breathing LED driver with a shared PWM base counter.
// Per channel: off / on / breath / blink, registered LED pins.
module breath_pwm_multi
  import breath_pwm_multi_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int PWM_STEPS  = 4800,
  parameter int STEP_W     = 8,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit STAGGER    = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_restart,
  input  logic [2*CHANNELS-1:0] i_mode,
  input  logic [STEP_W-1:0]     i_step,
  output logic [CHANNELS-1:0]   o_led,
  output logic                  o_period_tick,
  output logic [CHANNELS-1:0]   o_peak
);

  localparam int MAX   = PWM_STEPS - 1;
  localparam int CNT_W = clog2w(PWM_STEPS);
  localparam int STAG  = MAX / CHANNELS;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);
  localparam logic [CHANNELS-1:0] DARK =
    {CHANNELS{ACTIVE_LOW}};

  logic [CNT_W-1:0]    r_base;
  logic [CHANNELS-1:0] r_led;
  logic                w_tick;
  logic [CHANNELS-1:0] w_lit;

  assign w_tick = (r_base == MAX_C);

  // Free-running base counter 0..MAX.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      r_base <= '0;
    end else if (w_tick) begin
      r_base <= '0;
    end else begin
      r_base <= r_base + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam logic [CNT_W-1:0] INIT =
      STAGGER ? CNT_W'(gi * STAG) : '0;

    logic [1:0]       w_mode;
    logic [CNT_W-1:0] w_duty;
    logic             w_dir;
    logic             w_on;

    assign w_mode = i_mode[2*gi +: 2];

    breath_ramp #(
      .CNT_W  (CNT_W),
      .STEP_W (STEP_W),
      .MAX    (MAX)
    ) u_ramp (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_restart (i_restart),
      .i_tick    (w_tick),
      .i_mode    (w_mode),
      .i_step    (i_step),
      .i_init    (INIT),
      .o_duty    (w_duty),
      .o_dir     (w_dir),
      .o_peak    (o_peak[gi])
    );

    // Lit decision for this channel from its mode.
    always_comb begin
      w_on = 1'b0;
      unique case (w_mode)
        MODE_OFF:    w_on = 1'b0;
        MODE_ON:     w_on = 1'b1;
        MODE_BREATH: w_on = (w_duty > r_base);
        MODE_BLINK:  w_on = !w_dir;
        default:     w_on = 1'b0;
      endcase
    end

    assign w_lit[gi] = w_on;
  end

  // Pin register applies polarity; dark on reset and restart.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      r_led <= DARK;
    end else begin
      r_led <= w_lit ^ DARK;
    end
  end

  assign o_led         = r_led;
  assign o_period_tick = w_tick;

endmodule
